// File: rtl/bus_arbiter.sv
// ============================================================================
// bus_arbiter : shares one memory bus between fetch (IF) and data (MEM) ports
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bus_arbiter #(
    parameter int MAX_DATA_RUN = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ready_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        stallreq_if_o,
    output logic        stallreq_mem_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [3:0] C_MAX_RUN      = 4'(MAX_DATA_RUN);
    localparam logic       C_TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  run_cnt_q, run_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        mem_ready_q, mem_ready_d;
    logic        bus_err_q, bus_err_d;
    logic        w_timeout;

    assign w_timeout = C_TIMEOUT_EN && (wait_cnt_q == C_TIMEOUT_LAST);

    always_comb begin
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Data wins unless fetch has waited through MAX_DATA_RUN data grants
                if (mem_req_i && (!if_req_i || (run_cnt_q < C_MAX_RUN))) begin
                    state_d     = MEM_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we_i;
                    bus_sel_d   = mem_sel_i;
                    bus_addr_d  = mem_addr_i;
                    bus_wdata_d = mem_wdata_i;
                    wait_cnt_d  = 8'd0;
                    if (if_req_i)
                        run_cnt_d = (run_cnt_q == 4'd15) ? 4'd15 : run_cnt_q + 4'd1;
                    else
                        run_cnt_d = 4'd0;
                end else if (if_req_i) begin
                    state_d     = IF_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = 4'hF;
                    bus_addr_d  = if_addr_i;
                    bus_wdata_d = 32'd0;
                    wait_cnt_d  = 8'd0;
                    run_cnt_d   = 4'd0;
                end
            end
            IF_BUSY: begin
                if (bus_ack_i) begin
                    state_d    = DONE;
                    bus_req_d  = 1'b0;
                    if_ready_d = 1'b1;
                    if_data_d  = bus_rdata_i;
                end else if (w_timeout) begin
                    state_d    = DONE;
                    bus_req_d  = 1'b0;
                    if_ready_d = 1'b1;
                    if_data_d  = 32'd0;
                    bus_err_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            MEM_BUSY: begin
                if (bus_ack_i) begin
                    state_d     = DONE;
                    bus_req_d   = 1'b0;
                    mem_ready_d = 1'b1;
                    if (!bus_we_q)
                        mem_rdata_d = bus_rdata_i;
                end else if (w_timeout) begin
                    state_d     = DONE;
                    bus_req_d   = 1'b0;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = 32'd0;
                    bus_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            run_cnt_q   <= 4'd0;
            wait_cnt_q  <= 8'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'd0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus_req_o      = bus_req_q;
    assign bus_we_o       = bus_we_q;
    assign bus_sel_o      = bus_sel_q;
    assign bus_addr_o     = bus_addr_q;
    assign bus_wdata_o    = bus_wdata_q;
    assign if_data_o      = if_data_q;
    assign if_ready_o     = if_ready_q;
    assign mem_rdata_o    = mem_rdata_q;
    assign mem_ready_o    = mem_ready_q;
    assign bus_err_o      = bus_err_q;
    assign stallreq_if_o  = if_req_i & ~if_ready_q;
    assign stallreq_mem_o = mem_req_i & ~mem_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// tb_bus_arbiter : directed vector table plus multi-cycle corner sequences
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ready_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ready_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        stallreq_if_o;
    logic        stallreq_mem_o;
    logic        bus_err_o;

    int n_vec  = 0;
    int n_fail = 0;

    bus_arbiter #(.MAX_DATA_RUN(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_data_o(if_data_o), .if_ready_o(if_ready_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o), .mem_ready_o(mem_ready_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
        .bus_err_o(bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        mem_req;
        logic        mem_we;
        logic [3:0]  mem_sel;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_if_rdy;
        logic [31:0] e_if_data;
        logic        e_mem_rdy;
        logic [31:0] e_mem_rdata;
        logic        e_err;
        logic        e_stall_if;
        logic        e_stall_mem;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic drive_idle();
        if_req_i    = 1'b0;
        if_addr_i   = 32'd0;
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        mem_sel_i   = 4'd0;
        mem_addr_i  = 32'd0;
        mem_wdata_i = 32'd0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'd0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_bus_req", 32'(bus_req_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int w;
        logic found;

        //         ifreq ifaddr        memreq we    sel    maddr         mwdata        ack   rdata
        //         | req  we   sel    addr          wdata         ifrdy ifdata        mrdy  mrdata        err  sif  smem
        vecs[0]  = '{1'b0, 32'h0,      1'b0, 1'b0, 4'h0, 32'h0,      32'h0,        1'b0, 32'h0,
                     1'b0, 1'b0, 4'h0, 32'h0,      32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h100,    1'b0, 1'b0, 4'h0, 32'h0,      32'h0,        1'b0, 32'h0,
                     1'b1, 1'b0, 4'hF, 32'h100,    32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 32'h200,    1'b0, 1'b0, 4'h0, 32'h0,      32'h0,        1'b0, 32'h0,
                     1'b1, 1'b0, 4'hF, 32'h100,    32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 32'h200,    1'b0, 1'b0, 4'h0, 32'h0,      32'h0,        1'b1, 32'h3C010001,
                     1'b0, 1'b0, 4'hF, 32'h100,    32'h0,        1'b1, 32'h3C010001, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,      1'b0, 1'b0, 4'h0, 32'h0,      32'h0,        1'b0, 32'h0,
                     1'b0, 1'b0, 4'hF, 32'h100,    32'h0,        1'b0, 32'h3C010001, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,      1'b1, 1'b1, 4'h3, 32'h40,     32'hDEADBEEF, 1'b0, 32'h0,
                     1'b1, 1'b1, 4'h3, 32'h40,     32'hDEADBEEF, 1'b0, 32'h3C010001, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 32'h0,      1'b1, 1'b1, 4'h3, 32'h40,     32'hDEADBEEF, 1'b1, 32'h12345678,
                     1'b0, 1'b1, 4'h3, 32'h40,     32'hDEADBEEF, 1'b0, 32'h3C010001, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,      1'b0, 1'b0, 4'h0, 32'h0,      32'h0,        1'b0, 32'h0,
                     1'b0, 1'b1, 4'h3, 32'h40,     32'hDEADBEEF, 1'b0, 32'h3C010001, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'h104,    1'b1, 1'b0, 4'hF, 32'h2000,   32'h0,        1'b0, 32'h0,
                     1'b1, 1'b0, 4'hF, 32'h2000,   32'h0,        1'b0, 32'h3C010001, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 32'h104,    1'b1, 1'b0, 4'hF, 32'h2000,   32'h0,        1'b1, 32'hAABBCCDD,
                     1'b0, 1'b0, 4'hF, 32'h2000,   32'h0,        1'b0, 32'h3C010001, 1'b1, 32'hAABBCCDD, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 32'h104,    1'b0, 1'b0, 4'h0, 32'h0,      32'h0,        1'b0, 32'h0,
                     1'b0, 1'b0, 4'hF, 32'h2000,   32'h0,        1'b0, 32'h3C010001, 1'b0, 32'hAABBCCDD, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 32'h104,    1'b0, 1'b0, 4'h0, 32'h0,      32'h0,        1'b0, 32'h0,
                     1'b1, 1'b0, 4'hF, 32'h104,    32'h0,        1'b0, 32'h3C010001, 1'b0, 32'hAABBCCDD, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 32'h104,    1'b0, 1'b0, 4'h0, 32'h0,      32'h0,        1'b1, 32'h11112222,
                     1'b0, 1'b0, 4'hF, 32'h104,    32'h0,        1'b1, 32'h11112222, 1'b0, 32'hAABBCCDD, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 32'h0,      1'b0, 1'b0, 4'h0, 32'h0,      32'h0,        1'b1, 32'hFFFFFFFF,
                     1'b0, 1'b0, 4'hF, 32'h104,    32'h0,        1'b0, 32'h11112222, 1'b0, 32'hAABBCCDD, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 32'h0,      1'b0, 1'b0, 4'h0, 32'h0,      32'h0,        1'b1, 32'hEEEEEEEE,
                     1'b0, 1'b0, 4'hF, 32'h104,    32'h0,        1'b0, 32'h11112222, 1'b0, 32'hAABBCCDD, 1'b0, 1'b0, 1'b0};

        do_reset();

        for (int i = 0; i < NVEC; i++) begin
            if_req_i    = vecs[i].if_req;
            if_addr_i   = vecs[i].if_addr;
            mem_req_i   = vecs[i].mem_req;
            mem_we_i    = vecs[i].mem_we;
            mem_sel_i   = vecs[i].mem_sel;
            mem_addr_i  = vecs[i].mem_addr;
            mem_wdata_i = vecs[i].mem_wdata;
            bus_ack_i   = vecs[i].ack;
            bus_rdata_i = vecs[i].rdata;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d bus_req", i),   32'(bus_req_o),      32'(vecs[i].e_req));
            chk($sformatf("v%0d bus_we", i),    32'(bus_we_o),       32'(vecs[i].e_we));
            chk($sformatf("v%0d bus_sel", i),   32'(bus_sel_o),      32'(vecs[i].e_sel));
            chk($sformatf("v%0d bus_addr", i),  bus_addr_o,          vecs[i].e_addr);
            chk($sformatf("v%0d bus_wdata", i), bus_wdata_o,         vecs[i].e_wdata);
            chk($sformatf("v%0d if_ready", i),  32'(if_ready_o),     32'(vecs[i].e_if_rdy));
            chk($sformatf("v%0d if_data", i),   if_data_o,           vecs[i].e_if_data);
            chk($sformatf("v%0d mem_ready", i), 32'(mem_ready_o),    32'(vecs[i].e_mem_rdy));
            chk($sformatf("v%0d mem_rdata", i), mem_rdata_o,         vecs[i].e_mem_rdata);
            chk($sformatf("v%0d bus_err", i),   32'(bus_err_o),      32'(vecs[i].e_err));
            chk($sformatf("v%0d stall_if", i),  32'(stallreq_if_o),  32'(vecs[i].e_stall_if));
            chk($sformatf("v%0d stall_mem", i), 32'(stallreq_mem_o), 32'(vecs[i].e_stall_mem));
        end

        // Fetch starvation guard: four data grants, then fetch, then data again
        do_reset();
        mem_req_i  = 1'b1;
        mem_sel_i  = 4'hF;
        mem_addr_i = 32'h3000;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h500;
        for (int g = 0; g < 6; g++) begin
            found = 1'b0;
            w = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                #1;
                if (bus_req_o) begin
                    found = 1'b1;
                    w = i;
                    break;
                end
            end
            chk($sformatf("g%0d grant_seen", g), 32'(found), 32'd1);
            chk($sformatf("g%0d grant_order", g), bus_addr_o, (g == 4) ? 32'h500 : 32'h3000);
            if (g > 0)
                chk($sformatf("g%0d grant_spacing", g), 32'(w + 2), 32'd3);
            bus_ack_i   = 1'b1;
            bus_rdata_i = 32'h0;
            @(posedge clk);
            #1;
            bus_ack_i = 1'b0;
        end

        // No-ack timeout, preceded by a normal read so the zeroed data is observable
        do_reset();
        mem_req_i  = 1'b1;
        mem_sel_i  = 4'hF;
        mem_addr_i = 32'h80;
        @(posedge clk);
        #1;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        chk("pre_timeout_rdata", mem_rdata_o, 32'hCAFEF00D);
        bus_ack_i  = 1'b0;
        mem_req_i  = 1'b0;
        @(posedge clk);
        #1;
        mem_req_i  = 1'b1;
        mem_addr_i = 32'h84;
        @(posedge clk);
        #1;
        chk("to_grant", 32'(bus_req_o), 32'd1);
        w = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus_err_o) begin
                w = i;
                break;
            end
        end
        chk("to_cycle", 32'(w), 32'd16);
        chk("to_mem_ready", 32'(mem_ready_o), 32'd1);
        chk("to_mem_rdata", mem_rdata_o, 32'd0);
        chk("to_bus_req", 32'(bus_req_o), 32'd0);
        mem_req_i = 1'b0;
        @(posedge clk);
        #1;
        chk("to_err_one_cycle", 32'(bus_err_o), 32'd0);
        chk("to_ready_one_cycle", 32'(mem_ready_o), 32'd0);
        mem_req_i  = 1'b1;
        mem_addr_i = 32'h88;
        @(posedge clk);
        #1;
        chk("after_to_grant", 32'(bus_req_o), 32'd1);
        chk("after_to_addr", bus_addr_o, 32'h88);
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h0BADC0DE;
        @(posedge clk);
        #1;
        chk("after_to_ready", 32'(mem_ready_o), 32'd1);
        chk("after_to_rdata", mem_rdata_o, 32'h0BADC0DE);
        chk("after_to_no_err", 32'(bus_err_o), 32'd0);
        bus_ack_i = 1'b0;
        mem_req_i = 1'b0;

        // Reset asserted mid-transaction
        do_reset();
        mem_req_i  = 1'b1;
        mem_sel_i  = 4'hF;
        mem_addr_i = 32'h90;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h600;
        @(posedge clk);
        #1;
        chk("rst_pre_req", 32'(bus_req_o), 32'd1);
        chk("rst_pre_addr", bus_addr_o, 32'h90);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_drop", 32'(bus_req_o), 32'd0);
        mem_req_i = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_no_ready", 32'(mem_ready_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_if_grant", 32'(bus_req_o), 32'd1);
        chk("rst_if_addr", bus_addr_o, 32'h600);
        chk("rst_still_no_ready", 32'(mem_ready_o), 32'd0);
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h00000077;
        @(posedge clk);
        #1;
        chk("rst_if_ready", 32'(if_ready_o), 32'd1);
        chk("rst_if_data", if_data_o, 32'h00000077);
        bus_ack_i = 1'b0;
        if_req_i  = 1'b0;
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one single-ported memory bus between the instruction-fetch requester (IF) and the data-access requester (MEM stage).
- Sequences each bus transaction with a request/acknowledge handshake and returns read data to the winner.
- Generates per-requester stall requests for the pipeline control logic.
- Fixed data-over-fetch priority, with a starvation guard for fetch and a no-ack timeout.

Parameters:
- MAX_DATA_RUN, 4: consecutive MEM grants allowed while IF waits before IF is forced a grant (1..15).
- TIMEOUT, 16: cycles in a busy state without bus_ack_i before abort; 0 disables the timeout (0..255).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- if_req_i  input  1  fetch request, held until if_ready_o
- if_addr_i  input  32  fetch address
- if_data_o  output  32  fetched instruction, valid with if_ready_o
- if_ready_o  output  1  one-cycle fetch completion pulse
- mem_req_i  input  1  data request, held until mem_ready_o
- mem_we_i  input  1  1=write, 0=read
- mem_sel_i  input  4  byte enables
- mem_addr_i  input  32  data address
- mem_wdata_i  input  32  write data
- mem_rdata_o  output  32  read data, valid with mem_ready_o
- mem_ready_o  output  1  one-cycle data completion pulse
- bus_req_o  output  1  bus transaction active
- bus_we_o  output  1  bus write enable
- bus_sel_o  output  4  bus byte enables (4'hF for fetch)
- bus_addr_o  output  32  bus address
- bus_wdata_o  output  32  bus write data (0 for fetch)
- bus_rdata_i  input  32  bus read data, valid with bus_ack_i
- bus_ack_i  input  1  bus completion
- stallreq_if_o  output  1  if_req_i & ~if_ready_o (combinational)
- stallreq_mem_o  output  1  mem_req_i & ~mem_ready_o (combinational)
- bus_err_o  output  1  one-cycle timeout pulse

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; run and wait counters cleared.
  - All registered outputs 0, including if_data_o and mem_rdata_o.
  - Reset asserted mid-transaction drops bus_req_o immediately; no ready pulse is issued for the aborted transaction.
- States: IDLE, IF_BUSY, MEM_BUSY, DONE.
- IDLE grant decision:
  - MEM wins if mem_req_i && (!if_req_i || run_cnt < MAX_DATA_RUN).
  - Otherwise IF wins if if_req_i.
  - On a grant edge, bus_* outputs are registered from the winner's fields, bus_req_o goes to 1, and the state moves to the matching BUSY state.
- run_cnt update on a grant edge:
  - MEM grant with if_req_i=1: increment, saturating at 15.
  - MEM grant with if_req_i=0: clear.
  - IF grant: clear.
- BUSY with bus_ack_i=1:
  - On that edge: bus_req_o goes to 0, and ready goes to 1 for the owner for exactly one cycle.
  - Read data is captured into if_data_o or mem_rdata_o.
  - MEM writes leave mem_rdata_o unchanged.
  - State moves to DONE.
- DONE: one-cycle turnaround, no grant issued, then IDLE.
  - Back-to-back transactions are therefore spaced at least 3 cycles apart, grant edge to grant edge, when ack arrives in the first BUSY cycle.
- Latency: request sampled at edge N; bus_req_o high from N; ack sampled at edge N+k (k≥1); ready high during cycle N+k.
- wait_cnt:
  - Cleared on grant; increments each BUSY cycle without ack.
  - If TIMEOUT≠0 and wait_cnt reaches TIMEOUT-1 with no ack on that edge: bus_req_o goes to 0, the owner's ready pulses with data 0, bus_err_o pulses, and the state moves to DONE.
- bus_ack_i outside a BUSY state is ignored.
- A requester that drops its req while BUSY does not cancel the transaction: it still completes and the ready pulse still fires.
- Bus outputs hold their values throughout BUSY regardless of input changes.
- Simultaneous IF and MEM requests in IDLE are resolved by the grant rule above; the loser's stallreq stays high.

Test Plan:
- Reset then IF-only: if_addr_i=0x100, ack on 2nd busy cycle with rdata 0x3C010001 -> bus_addr_o=0x100, bus_sel_o=4'hF, if_ready_o one cycle, if_data_o=0x3C010001, stallreq_if_o low after ready.
- Simultaneous if_req_i and mem_req_i read at 0x2000 -> MEM granted first; IF granted after DONE; stallreq_if_o high until its ready.
- mem_req_i held continuously with if_req_i high, MAX_DATA_RUN=4, immediate acks -> grant order MEM,MEM,MEM,MEM,IF,MEM...
- MEM write: sel=4'b0011, wdata=0xDEADBEEF, addr 0x40 -> bus_we_o=1, bus_sel_o=4'b0011, mem_ready_o pulses, mem_rdata_o unchanged.
- No ack with TIMEOUT=16 -> bus_err_o and mem_ready_o pulse together on the 16th busy cycle, mem_rdata_o=0, bus_req_o low; next request is served normally.
- rst pulled low mid-MEM_BUSY -> bus_req_o=0 immediately, no ready pulse; after release, a pending IF request is granted from IDLE.
